// File: rtl/mac_pkg.sv
// Shared definitions for the MAC transmit-side arbiter: state encoding,
// Ethernet defaults and a small grant decoding helper.
package mac_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_DRAIN = 2'd2,
        ARB_GAP   = 2'd3
    } arb_state_e;

    localparam int ETH_MAX_FRAME = 1518;
    localparam int ETH_IFG_BYTES = 12;

    // Port index carried by a one-hot two-way grant.
    function automatic logic grant_port(input logic [1:0] grant);
        return grant[1];
    endfunction

endpackage

// File: rtl/mac_tx_arbiter_if.sv
// Bundle of both requester byte streams, the MAC byte stream and the
// arbiter status outputs. slave is the arbiter side, master the environment.
interface mac_tx_arbiter_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] req0_data;
    logic              req0_valid;
    logic              req0_last;
    logic              req0_err;
    logic              req0_ready;
    logic [DATA_W-1:0] req1_data;
    logic              req1_valid;
    logic              req1_last;
    logic              req1_err;
    logic              req1_ready;
    logic [DATA_W-1:0] tx_mac_data;
    logic              tx_mac_valid;
    logic              tx_mac_last;
    logic              tx_mac_err;
    logic              tx_mac_ready;
    logic [1:0]        arb_grant;
    logic              arb_trunc;

    modport slave (
        input  req0_data, req0_valid, req0_last, req0_err,
        input  req1_data, req1_valid, req1_last, req1_err,
        input  tx_mac_ready,
        output req0_ready, req1_ready,
        output tx_mac_data, tx_mac_valid, tx_mac_last, tx_mac_err,
        output arb_grant, arb_trunc
    );

    modport master (
        output req0_data, req0_valid, req0_last, req0_err,
        output req1_data, req1_valid, req1_last, req1_err,
        output tx_mac_ready,
        input  req0_ready, req1_ready,
        input  tx_mac_data, tx_mac_valid, tx_mac_last, tx_mac_err,
        input  arb_grant, arb_trunc
    );

endinterface

// File: rtl/mac_rr_arb2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to
// the port that did not own the previous frame.
module mac_rr_arb2 (
    input  logic [1:0] req,
    input  logic       rr_last,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = rr_last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing one MAC TX byte stream between
// two requesters, with inter-frame gap and oversize truncation.
module mac_tx_arbiter
    import mac_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int IFG_CYCLES = ETH_IFG_BYTES,
    parameter int MAX_LEN    = ETH_MAX_FRAME,
    parameter int LEN_W      = 11
) (
    input  logic            tx_mac_clk,
    input  logic            reset,
    mac_tx_arbiter_if.slave bus
);

    localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
    localparam logic [LEN_W-1:0] LAST_COUNT = LEN_W'(MAX_LEN - 1);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic [1:0]        grant_q, grant_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              rr_last_q, rr_last_d;

    logic [1:0]        pick;
    logic [DATA_W-1:0] sel_data;
    logic              sel_valid, sel_last, sel_err;
    logic              at_max, frame_end, owner_ready, trunc;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid, tx_last, tx_err;

    mac_rr_arb2 u_rr (
        .req     ({bus.req1_valid, bus.req0_valid}),
        .rr_last (rr_last_q),
        .grant   (pick)
    );

    always_comb begin
        sel_data  = owner_q ? bus.req1_data  : bus.req0_data;
        sel_valid = owner_q ? bus.req1_valid : bus.req0_valid;
        sel_last  = owner_q ? bus.req1_last  : bus.req0_last;
        sel_err   = owner_q ? bus.req1_err   : bus.req0_err;
        at_max    = (count_q == LAST_COUNT);
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        grant_d     = grant_q;
        count_d     = count_q;
        gap_d       = gap_q;
        rr_last_d   = rr_last_q;
        frame_end   = 1'b0;
        owner_ready = 1'b0;
        trunc       = 1'b0;
        tx_data     = '0;
        tx_valid    = 1'b0;
        tx_last     = 1'b0;
        tx_err      = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (pick != 2'b00) begin
                    grant_d = pick;
                    owner_d = grant_port(pick);
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                // The MAX_LEN-th beat is forced to end the frame unless the requester ends it anyway.
                tx_data     = sel_data;
                tx_valid    = sel_valid;
                tx_last     = sel_last | at_max;
                tx_err      = sel_err | (at_max & ~sel_last);
                owner_ready = bus.tx_mac_ready;
                if (sel_valid && bus.tx_mac_ready) begin
                    if (sel_last) begin
                        frame_end = 1'b1;
                    end else if (at_max) begin
                        trunc   = 1'b1;
                        count_d = '0;
                        state_d = ARB_DRAIN;
                    end else begin
                        count_d = count_q + LEN_W'(1);
                    end
                end
            end
            ARB_DRAIN: begin
                owner_ready = 1'b1;
                if (sel_valid && sel_last) begin
                    frame_end = 1'b1;
                end
            end
            ARB_GAP: begin
                if (gap_q == '0) begin
                    state_d = ARB_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
        endcase

        if (frame_end) begin
            rr_last_d = owner_q;
            count_d   = '0;
            grant_d   = 2'b00;
            gap_d     = GAP_LOAD;
            state_d   = (IFG_CYCLES == 0) ? ARB_IDLE : ARB_GAP;
        end
    end

    always_ff @(posedge tx_mac_clk) begin
        if (!reset) begin
            state_q   <= ARB_IDLE;
            owner_q   <= 1'b0;
            grant_q   <= 2'b00;
            count_q   <= '0;
            gap_q     <= '0;
            rr_last_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            count_q   <= count_d;
            gap_q     <= gap_d;
            rr_last_q <= rr_last_d;
        end
    end

    assign bus.req0_ready   = owner_ready & ~owner_q;
    assign bus.req1_ready   = owner_ready & owner_q;
    assign bus.tx_mac_data  = tx_data;
    assign bus.tx_mac_valid = tx_valid;
    assign bus.tx_mac_last  = tx_last;
    assign bus.tx_mac_err   = tx_err;
    assign bus.arb_grant    = grant_q;
    assign bus.arb_trunc    = trunc;

endmodule

// File: doc/mac_tx_arbiter.md
Name: mac_tx_arbiter

Overview:
- Shares the single mac_controller TX byte stream (tx_mac_data/valid/last/err/ready) between two bridge-port requesters.
- Grants whole frames only, alternating round-robin at frame boundaries.
- Enforces a minimum idle gap between granted frames.
- Truncates any frame that exceeds MAX_LEN bytes by forcing last+err to the MAC, then silently drains the rest of that frame from the requester.

Parameters:
- DATA_W, 8, byte-stream width.
- IFG_CYCLES, 12, idle clocks between the accepted last beat and the next grant. 0 means return directly to IDLE.
- MAX_LEN, 1518, maximum bytes forwarded per frame, range 2..2047.
- LEN_W, 11, byte counter width. Must satisfy 2^LEN_W > MAX_LEN.

Ports:
- tx_mac_clk  in  1  Single clock. Reset is synchronous and active-low.
- reset  in  1  Synchronous, active-low reset.
- req0_data  in  DATA_W  Requester 0 byte.
- req0_valid  in  1  Requester 0 beat valid.
- req0_last  in  1  Requester 0 final beat of frame.
- req0_err  in  1  Requester 0 error flag, forwarded unchanged.
- req0_ready  out  1  Requester 0 beat accepted.
- req1_data, req1_valid, req1_last, req1_err  in  Same as requester 0.
- req1_ready  out  1  Requester 1 beat accepted.
- tx_mac_data  out  DATA_W  To the MAC.
- tx_mac_valid  out  1  To the MAC.
- tx_mac_last  out  1  To the MAC.
- tx_mac_err  out  1  To the MAC.
- tx_mac_ready  in  1  From the MAC.
- arb_grant  out  2  One-hot current owner, registered. 00 when no owner.
- arb_trunc  out  1  One-cycle pulse on the forced-last beat.

Behaviour:
- Transfer rule: a beat transfers when valid and ready are both high in the same cycle. Valid must never depend on ready; ready may depend on valid.
- Reset (reset=0 at a tx_mac_clk edge):
  - state=IDLE, arb_grant=00, byte count=0, gap count=0, rr_last=1 (so port 0 wins the first tie).
  - Reset is honoured mid-frame. The in-flight frame is abandoned with no last and no err. Both the requester and the MAC must be reset together.
- Outputs while not in GRANT: all tx_mac_* outputs are 0. req_ready is 0 except as stated for DRAIN.
- IDLE:
  - Sample req*_valid.
  - One valid: grant it. Both valid: grant port (~rr_last).
  - arb_grant registers the winner, state goes to GRANT next cycle. This is one cycle of arbitration latency, with no beat in the decision cycle.
- GRANT (owner k): combinational pass-through, zero latency.
  - tx_mac_data/valid/last/err = reqk_*.
  - reqk_ready = tx_mac_ready. The other port's ready = 0.
  - Byte count increments on each transfer.
- Transfer with reqk_last=1 (count < MAX_LEN): rr_last<=k, count<=0, then go to GAP, or to IDLE if IFG_CYCLES=0.
- Truncation: a transfer when count==MAX_LEN-1 and reqk_last=0.
  - The beat is presented with tx_mac_last=1 and tx_mac_err=1, both forced combinationally when count==MAX_LEN-1.
  - arb_trunc pulses in that cycle. Next state is DRAIN.
  - If reqk_last=1 on the MAX_LEN-th beat, treat it as a normal end: no err forcing beyond reqk_err, no pulse.
- DRAIN:
  - reqk_ready=1 and tx_mac_valid=0. Beats are discarded.
  - When a beat with reqk_last=1 is accepted: rr_last<=k, then GAP or IDLE.
- GAP:
  - The gap counter loads IFG_CYCLES-1 on entry and decrements each cycle. At 0, go to IDLE.
  - Total idle between the last beat and the next first beat is therefore IFG_CYCLES + 1 cycles (gap plus arbitration).
- arb_grant is 00 in IDLE and GAP, and shows owner k in GRANT and DRAIN.
- A requester dropping valid mid-frame is legal. The grant is held until last; there is no timeout.
- A simultaneous new request from the other port during GRANT has no effect until IDLE.
- Widths: the byte count never wraps, because it is bounded by MAX_LEN < 2^LEN_W.

Decomposition:
- Shared package mac_pkg:
  - Arbiter state encoding: IDLE=2'd0, GRANT=2'd1, DRAIN=2'd2, GAP=2'd3.
  - ETH_MAX_FRAME=1518.
  - ETH_IFG_BYTES=12.
- One natural sub-module: mac_rr_arb2, a 2-way round-robin picker (req[1:0], rr_last → grant one-hot), purely combinational.
- The FSM, counters and mux stay in the top module.

Test Plan:
- Single frame: req0 sends 64 bytes 0x00..0x3F with last on the 64th, tx_mac_ready=1.
  - Expect arb_grant=01 one cycle after req0_valid.
  - tx_mac_data reproduces 0x00..0x3F with last on 0x3F and err=0.
  - arb_grant=00 on the following cycle.
- Tie: req0 and req1 both valid from reset, each with 4-byte frames.
  - Expect order port0, port1, port0, port1.
  - Exactly 13 idle cycles between each last beat and the next first beat (IFG_CYCLES=12).
- Backpressure: tx_mac_ready toggles 1,0,1,0 during a 10-byte frame from req1.
  - req1_ready mirrors tx_mac_ready exactly.
  - 10 transfers, no duplicated or dropped bytes.
  - req0_ready stays 0 throughout.
- Oversize: MAX_LEN=16, req0 sends 20 bytes with last on byte 20.
  - The MAC sees 16 beats; the 16th carries last=1 and err=1.
  - arb_trunc pulses once.
  - Bytes 17..20 are accepted with tx_mac_valid=0.
  - GAP follows the 20th byte.
- Reset mid-frame: reset=0 for one cycle after 5 of 30 bytes.
  - Next cycle: arb_grant=00 and all tx_mac_* outputs 0.
  - After reset releases, a new req1 frame is granted first (rr_last=1 reset default, port 0 idle).
